// File: rtl/a2d_spi_intf.sv
// SPI master for an ADC128S-style converter: two 16-bit frames per conversion,
// channel sent in frame 1, result read back in frame 2.
module a2d_spi_intf #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int CW = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] CNT_FALL = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] CNT_RISE = CW'(SCLK_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(SCLK_DIV / 2);

    typedef enum logic [1:0] {IDLE, TX1, GAP, TX2} state_t;

    state_t          state, nxt_state;
    logic [CW-1:0]   cnt;
    logic [4:0]      bit_cnt;
    logic [15:0]     tx_shft;
    // Only the low 12 sampled bits are ever used, so older bits fall off the top.
    logic [11:0]     rx_shft;
    logic [2:0]      chnnl_lat;
    logic            ss_n_r;
    logic            cmplt_r;
    logic [11:0]     res_r;

    logic            in_tx;
    logic            sclk_fall;
    logic            sclk_rise;
    logic            tx_done;
    logic            start;
    logic [2:0]      cmd_chnnl;

    assign in_tx     = (state == TX1) || (state == TX2);
    assign sclk_fall = (cnt == CNT_FALL);
    assign sclk_rise = (cnt == CNT_RISE);
    // The frame ends half an SCLK period after the 16th rise, where the next fall would be.
    assign tx_done   = in_tx && (bit_cnt == 5'd16) && sclk_fall;
    assign cmd_chnnl = (state == IDLE) ? chnnl : chnnl_lat;

    always_comb begin
        nxt_state = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (strt_cnv) begin
                    nxt_state = TX1;
                    start     = 1'b1;
                end
            end
            TX1: begin
                if (tx_done) nxt_state = GAP;
            end
            GAP: begin
                if (sclk_fall) begin
                    nxt_state = TX2;
                    start     = 1'b1;
                end
            end
            TX2: begin
                if (tx_done) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            tx_shft   <= '0;
            rx_shft   <= '0;
            chnnl_lat <= '0;
            ss_n_r    <= 1'b1;
            cmplt_r   <= 1'b0;
            res_r     <= '0;
        end else begin
            state <= nxt_state;
            if (start) begin
                cnt     <= CNT_HALF;
                bit_cnt <= '0;
                tx_shft <= {2'b00, cmd_chnnl, 11'h000};
                rx_shft <= '0;
                ss_n_r  <= 1'b0;
                if (state == IDLE) begin
                    chnnl_lat <= chnnl;
                    cmplt_r   <= 1'b0;
                end
            end else if (tx_done) begin
                // Restart the divider so GAP lasts exactly one SCLK period.
                ss_n_r <= 1'b1;
                cnt    <= '0;
                if (state == TX2) begin
                    res_r   <= rx_shft;
                    cmplt_r <= 1'b1;
                end
            end else if (state != IDLE) begin
                cnt <= cnt + CW'(1);
                if (in_tx && sclk_fall && (bit_cnt != 5'd16))
                    tx_shft <= {tx_shft[14:0], 1'b0};
                if (in_tx && sclk_rise) begin
                    rx_shft <= {rx_shft[10:0], MISO};
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
        end
    end

    assign SS_n      = ss_n_r;
    assign SCLK      = ss_n_r ? 1'b1 : cnt[CW-1];
    assign MOSI      = tx_shft[15];
    assign cnv_cmplt = cmplt_r;
    assign res       = res_r;

endmodule

// File: tb/tb_a2d_spi_intf.sv
// Scoreboard bench for a2d_spi_intf with a behavioural ADC on the SPI pins.
module tb_a2d_spi_intf;

    localparam int DIV = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl = 3'd0;
    logic        MISO = 1'b0;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;

    a2d_spi_intf #(.SCLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .res(res), .SS_n(SS_n), .SCLK(SCLK),
        .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e0;
        logic [15:0] cmd;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [11:0] res;
    } conv_t;

    conv_t exp_q[$];
    conv_t cur;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int sclk_edges = 0;
    int n_cmplt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model and SPI monitor, sampled on the falling clk edge.
    logic        prev_ss = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0, prev_cmplt = 1'b0;
    logic        in_txn = 1'b0;
    int          txn_idx = 0;
    int          falls = 0;
    logic [15:0] cmd_cap = '0;
    logic [15:0] mw;

    always @(negedge clk) begin
        if (SCLK !== prev_sclk) sclk_edges++;
        if (rst) begin
            in_txn  = 1'b0;
            txn_idx = 0;
            MISO    = 1'b0;
        end else begin
            if (prev_ss && !SS_n) begin
                if (txn_idx == 0) begin
                    if (exp_q.size() > 0) cur = exp_q.pop_front();
                    else begin
                        check("unexpected_txn", 1, 0);
                        cur = '{-1000000, 16'h0, 16'h0, 16'h0, 12'h0};
                    end
                end
                check(txn_idx == 0 ? "ss_fall1_time" : "ss_fall2_time",
                      cyc, cur.e0 + (txn_idx == 0 ? 0 : DIV * 35 / 2));
                in_txn  = 1'b1;
                falls   = 0;
                cmd_cap = '0;
                MISO    = 1'b0;
            end else if (in_txn && prev_sclk && !SCLK) begin
                cmd_cap = {cmd_cap[14:0], prev_mosi};
                mw = (txn_idx == 0) ? cur.w1 : cur.w2;
                MISO = (falls < 16) ? mw[15 - falls] : 1'b0;
                falls++;
            end
            if (in_txn && !prev_ss && SS_n) begin
                check("sclk_falls", falls, 16);
                check(txn_idx == 0 ? "cmd1" : "cmd2", cmd_cap, cur.cmd);
                check(txn_idx == 0 ? "ss_rise1_time" : "ss_rise2_time",
                      cyc, cur.e0 + (txn_idx == 0 ? DIV * 33 / 2 : DIV * 34));
                in_txn  = 1'b0;
                txn_idx = 1 - txn_idx;
            end
            if (!prev_cmplt && cnv_cmplt) begin
                n_cmplt++;
                check("cmplt_time", cyc, cur.e0 + DIV * 34);
                check("res", res, cur.res);
            end
        end
        prev_ss    = SS_n;
        prev_sclk  = SCLK;
        prev_mosi  = MOSI;
        prev_cmplt = cnv_cmplt;
    end

    // Caller must be just after a rising edge; strt_cnv is sampled on the next one.
    task automatic start_conv(input logic [2:0] ch, input logic [15:0] w1,
                              input logic [15:0] w2, input bit accept);
        conv_t c;
        strt_cnv = 1'b1;
        chnnl    = ch;
        if (accept) begin
            c = '{cyc + 1, {2'b00, ch, 11'h000}, w1, w2, w2[11:0]};
            exp_q.push_back(c);
        end
        @(posedge clk); #1;
        strt_cnv = 1'b0;
        if (accept) check("cmplt_clear", cnv_cmplt, 1'b0);
    endtask

    task automatic wait_cmplt(input int budget);
        int n = 0;
        while (!cnv_cmplt && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cnv_cmplt) check("cmplt_timeout", 0, 1);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [2:0]  sweep [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
        logic [15:0] w;

        // Reset with a coincident start request, which reset must override.
        strt_cnv = 1'b1;
        chnnl    = 3'd5;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        strt_cnv = 1'b0;
        check("rst_ss_n", SS_n, 1'b1);
        check("rst_sclk", SCLK, 1'b1);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_cmplt", cnv_cmplt, 1'b0);
        check("rst_res", res, 12'h000);
        e = sclk_edges;
        repeat (2000) @(posedge clk); #1;
        check("idle_sclk_edges", sclk_edges, e);
        check("idle_ss_n", SS_n, 1'b1);

        // Single conversion on channel 3.
        start_conv(3'd3, 16'h5555, 16'h0ABC, 1'b1);
        wait_cmplt(1200);

        // Upper four result bits must be discarded.
        @(posedge clk); #1;
        start_conv(3'd6, 16'h1234, 16'hFFFF, 1'b1);
        wait_cmplt(1200);
        @(posedge clk); #1;
        start_conv(3'd1, 16'hFFFF, 16'hF000, 1'b1);
        wait_cmplt(1200);

        // A request while busy is dropped.
        @(posedge clk); #1;
        start_conv(3'd3, 16'h5555, 16'h0ABC, 1'b1);
        repeat (299) @(posedge clk); #1;
        start_conv(3'd7, 16'h0, 16'h0, 1'b0);
        wait_cmplt(1200);
        repeat (10) @(posedge clk); #1;
        check("cmplt_hold", cnv_cmplt, 1'b1);
        start_conv(3'd2, 16'h0F0F, 16'h0321, 1'b1);
        wait_cmplt(1200);

        // Back-to-back sweep, each issued the cycle completion is seen.
        foreach (sweep[i]) begin
            w = 16'hA000 | (16'(sweep[i]) << 8) | 16'(8'h30 + 8'(sweep[i]));
            start_conv(sweep[i], ~w, w, 1'b1);
            wait_cmplt(1200);
        end

        // Reset in the middle of TX2.
        check("pre_rst_res", res, 12'h737);
        start_conv(3'd5, 16'h1111, 16'h0456, 1'b1);
        repeat (699) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ss_n", SS_n, 1'b1);
        check("midrst_sclk", SCLK, 1'b1);
        check("midrst_cmplt", cnv_cmplt, 1'b0);
        check("midrst_res", res, 12'h000);
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        start_conv(3'd4, 16'h2222, 16'h0789, 1'b1);
        wait_cmplt(1200);

        repeat (5) @(posedge clk); #1;
        check("completions", n_cmplt, 12);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
